// File: rtl/can_bit_timing_gen.sv
// can_bit_timing_gen: CAN time-quantum prescaler and bit-timing FSM with hard sync, resync and (triple) sampling.
module can_bit_timing_gen #(
  parameter int BRP_W   = 6,
  parameter int TSEG1_W = 4,
  parameter int TSEG2_W = 3,
  parameter int SJW_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BRP_W-1:0]   baud_r_presc,
  input  logic [SJW_W-1:0]   sync_jump_width,
  input  logic [TSEG1_W-1:0] time_segment1,
  input  logic [TSEG2_W-1:0] time_segment2,
  input  logic               triple_sampling,
  input  logic               reset_mode,
  input  logic               rx,
  input  logic               transmitting,
  input  logic               hard_sync_en,
  output logic               clk_en,
  output logic               sample_point,
  output logic               sampled_bit,
  output logic               tx_point,
  output logic               hard_sync
);
  localparam int PW = BRP_W + 1;
  localparam int M1 = TSEG1_W > SJW_W ? TSEG1_W : SJW_W;
  localparam int MW = M1 > TSEG2_W ? M1 : TSEG2_W;
  localparam int QW = MW + 2;
  typedef enum logic [1:0] {IDLE, SYNC, SEG1, SEG2} state_t;
  state_t state, state_n;
  logic [PW-1:0] cnt;
  logic [QW-1:0] qcnt, qcnt_n, ext, ext_n, ext_nx, shr, shr_n, shr_nx, sjw1, e, r;
  logic tick, rx_q, edge_pend, ep, hs, rs, early, seg1_end, seg2_end, tx_n, sp_n, rd, rd_n, s1, s2, maj;
  assign tick = cnt == {baud_r_presc, 1'b1};
  assign sjw1 = QW'(sync_jump_width) + QW'(1);
  assign ep   = edge_pend | (rx_q & ~rx);
  assign maj  = (s1 & s2) | (s1 & rx) | (s2 & rx);
  always_comb begin
    e        = qcnt + QW'(1);
    r        = QW'(time_segment2) - qcnt;
    hs       = ep & hard_sync_en & (state != IDLE);
    rs       = ep & ~hard_sync_en & ~transmitting & ~rd;
    early    = (state == SEG2) & rs & (r < sjw1);
    ext_n    = ((state == SEG1) & rs) ? (e < sjw1 ? e : sjw1) : ext;
    shr_n    = ((state == SEG2) & rs & ~early) ? sjw1 : shr;
    seg1_end = (state == SEG1) & (qcnt == QW'(time_segment1) + ext_n);
    seg2_end = (state == SEG2) & (early | (qcnt == QW'(time_segment2) - shr_n));
    state_n  = (state == IDLE) ? SYNC :
               hs              ? SEG1 :
               (state == SYNC) ? SEG1 :
               seg1_end        ? SEG2 :
               seg2_end        ? SYNC : state;
    tx_n     = (state == IDLE) | (~hs & seg2_end);
    sp_n     = ~hs & seg1_end;
    qcnt_n   = (hs | (state_n != state)) ? '0 : e;
    rd_n     = tx_n ? 1'b0 : (hs | (rs & ((state == SEG1) | (state == SEG2)))) ? 1'b1 : rd;
    ext_nx   = (tx_n | hs) ? '0 : ext_n;
    shr_nx   = (tx_n | hs) ? '0 : shr_n;
  end
  always_ff @(posedge clk) begin
    if (rst | reset_mode) begin
      state        <= IDLE;
      cnt          <= '0;
      qcnt         <= '0;
      ext          <= '0;
      shr          <= '0;
      rd           <= 1'b0;
      rx_q         <= 1'b1;
      edge_pend    <= 1'b0;
      s1           <= 1'b1;
      s2           <= 1'b1;
      clk_en       <= 1'b0;
      sample_point <= 1'b0;
      tx_point     <= 1'b0;
      hard_sync    <= 1'b0;
      sampled_bit  <= 1'b1;
    end else begin
      rx_q         <= rx;
      cnt          <= tick ? '0 : cnt + PW'(1);
      edge_pend    <= ~tick & ep;
      clk_en       <= tick;
      tx_point     <= tick & tx_n;
      sample_point <= tick & sp_n;
      hard_sync    <= tick & hs;
      if (tick) begin
        state <= state_n;
        qcnt  <= qcnt_n;
        ext   <= ext_nx;
        shr   <= shr_nx;
        rd    <= rd_n;
        s2    <= s1;
        s1    <= rx;
        if (sp_n) sampled_bit <= (triple_sampling && time_segment1 != '0) ? maj : rx;
      end
    end
  end
endmodule
